// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush-driven bubble insertion and a registered ready toward upstream.
module pipe_stage_buf #(
    parameter int unsigned DATA_W     = 69,
    parameter int unsigned CTRL_W     = 2,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                main_vld_q, main_vld_d;
    logic                skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                ready_q, ready_d;
    logic [1:0]          count_q, count_d;

    logic                in_fire_c;
    logic                out_fire_c;

    assign in_fire_c  = valid_i & ready_q;
    assign out_fire_c = main_vld_q & ready_i;

    // Next-state and storage steering; main ctrl is kept zero whenever main is invalid
    always_comb begin
        state_d     = state_q;
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        ready_d     = ready_q;
        count_d     = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) begin
                    state_d     = ST_ONE;
                    main_vld_d  = 1'b1;
                    main_ctrl_d = ctrl_i;
                    main_data_d = data_i;
                end
            end
            ST_ONE: begin
                if (in_fire_c && out_fire_c) begin
                    main_ctrl_d = ctrl_i;
                    main_data_d = data_i;
                end else if (in_fire_c) begin
                    state_d     = ST_FULL;
                    skid_vld_d  = 1'b1;
                    skid_ctrl_d = ctrl_i;
                    skid_data_d = data_i;
                end else if (out_fire_c) begin
                    state_d     = ST_EMPTY;
                    main_vld_d  = 1'b0;
                    main_ctrl_d = '0;
                end
            end
            ST_FULL: begin
                // ready_q is low here, so only the drain path exists
                if (out_fire_c) begin
                    state_d     = ST_ONE;
                    skid_vld_d  = 1'b0;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                main_vld_d  = 1'b0;
                skid_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end
        endcase

        // Flush drops held entries and any offered input; a same-cycle OUT stays consumed
        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_ctrl_d = '0;
        end

        ready_d = (state_d != ST_FULL);
        case (state_d)
            ST_ONE:  count_d = 2'd1;
            ST_FULL: count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            ready_q     <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
        end
    end

    // Wide data payload only pays for a reset when the instance asks for it
    generate
        if (RESET_DATA) begin : g_data_rst
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk_i) begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    endgenerate

    assign ready_o = ready_q;
    assign valid_o = main_vld_q;
    assign data_o  = main_data_q;
    assign ctrl_o  = main_ctrl_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized
// run against a two-entry queue model of the stage.
module tb_pipe_stage_buf;

    localparam int unsigned DW = 69;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] data_in;
    logic [CW-1:0] ctrl_in;
    logic          flush;
    logic          valid_out;
    logic          ready_in;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic [1:0]    count_out;

    int checks;
    int failures;

    logic [DW-1:0] mq_d[$];
    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] model_out[$];
    logic [DW-1:0] dut_out[$];

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA(1'b1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_i  (data_in),
        .ctrl_i  (ctrl_in),
        .flush_i (flush),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (data_out),
        .ctrl_o  (ctrl_out),
        .count_o (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the queue model, log what DUT hands downstream
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic f, input logic r, input logic rdy);
        bit in_f;
        bit out_f;
        valid_in = v;
        data_in  = d;
        ctrl_in  = c;
        flush    = f;
        rst      = r;
        ready_in = rdy;
        in_f  = v && (mq_d.size() < 2);
        out_f = (mq_d.size() > 0) && rdy;
        if (!r && valid_out && rdy) dut_out.push_back(data_out);
        if (r) begin
            mq_d.delete();
            mq_c.delete();
        end else begin
            if (out_f) begin
                model_out.push_back(mq_d[0]);
                void'(mq_d.pop_front());
                void'(mq_c.pop_front());
            end
            if (f) begin
                mq_d.delete();
                mq_c.delete();
            end else if (in_f) begin
                mq_d.push_back(d);
                mq_c.push_back(c);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, DW'(0), CW'(0), 1'b0, 1'b0, rdy);
    endtask

    function automatic bit seen(input logic [DW-1:0] v);
        foreach (dut_out[i]) if (dut_out[i] === v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        step(1'b1, DW'(99), 2'b11, 1'b0, 1'b1, 1'b1);
        step(1'b1, DW'(98), 2'b11, 1'b0, 1'b1, 1'b1);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
        checks++; if (ctrl_out !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00", ctrl_out); end
        checks++; if (count_out !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        checks++; if (data_out !== DW'(0)) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
        dut_out.delete();
        model_out.delete();
    endtask

    task automatic test_streaming();
        dut_out.delete();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 2'b11, 1'b0, 1'b0, 1'b1);
            checks++; if (valid_out !== 1'b1 || data_out !== DW'(i)) begin
                failures++; $display("FAIL stream_head i=%0d got v=%b d=%0d exp v=1 d=%0d", i, valid_out, data_out, i); end
            checks++; if (ctrl_out !== 2'b11) begin failures++; $display("FAIL stream_ctrl got=%b exp=11", ctrl_out); end
            checks++; if (ready_out !== 1'b1 || count_out > 2'd1) begin
                failures++; $display("FAIL stream_ready_count got r=%b c=%0d exp r=1 c<=1", ready_out, count_out); end
        end
        idle(1'b1);
        checks++; if (valid_out !== 1'b0 || ctrl_out !== 2'b00 || count_out !== 2'd0) begin
            failures++; $display("FAIL stream_drain got v=%b ctrl=%b c=%0d exp 0/00/0", valid_out, ctrl_out, count_out); end
        checks++; if (dut_out.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", dut_out.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++; if (dut_out[i] !== DW'(i + 1)) begin
                failures++; $display("FAIL stream_order idx=%0d got=%0d exp=%0d", i, dut_out[i], i + 1); end
        end
    endtask

    task automatic test_backpressure();
        dut_out.delete();
        step(1'b1, DW'(10), 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, DW'(11), 2'b10, 1'b0, 1'b0, 1'b0);
        checks++; if (count_out !== 2'd2 || ready_out !== 1'b0 || data_out !== DW'(10)) begin
            failures++; $display("FAIL bp_skid got c=%0d r=%b d=%0d exp c=2 r=0 d=10", count_out, ready_out, data_out); end
        step(1'b1, DW'(12), 2'b11, 1'b0, 1'b0, 1'b0);
        checks++; if (count_out !== 2'd2 || ready_out !== 1'b0 || data_out !== DW'(10) || ctrl_out !== 2'b01) begin
            failures++; $display("FAIL bp_hold got c=%0d r=%b d=%0d ctrl=%b exp c=2 r=0 d=10 ctrl=01", count_out, ready_out, data_out, ctrl_out); end
        step(1'b1, DW'(12), 2'b11, 1'b0, 1'b0, 1'b1);
        checks++; if (count_out !== 2'd1 || ready_out !== 1'b1 || data_out !== DW'(11) || ctrl_out !== 2'b10) begin
            failures++; $display("FAIL bp_release got c=%0d r=%b d=%0d ctrl=%b exp c=1 r=1 d=11 ctrl=10", count_out, ready_out, data_out, ctrl_out); end
        step(1'b1, DW'(12), 2'b11, 1'b0, 1'b0, 1'b1);
        step(1'b1, DW'(13), 2'b00, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        checks++; if (dut_out.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", dut_out.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (dut_out[i] !== DW'(10 + i)) begin
                failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, dut_out[i], 10 + i); end
        end
    endtask

    task automatic test_flush();
        dut_out.delete();
        step(1'b1, DW'(20), 2'b11, 1'b0, 1'b0, 1'b1);
        step(1'b1, DW'(21), 2'b11, 1'b0, 1'b0, 1'b0);
        checks++; if (count_out !== 2'd2) begin failures++; $display("FAIL flush_prefull got=%0d exp=2", count_out); end
        step(1'b1, DW'(22), 2'b11, 1'b1, 1'b0, 1'b0);
        checks++; if (valid_out !== 1'b0 || ctrl_out !== 2'b00 || count_out !== 2'd0 || ready_out !== 1'b1) begin
            failures++; $display("FAIL flush_bubble got v=%b ctrl=%b c=%0d r=%b exp 0/00/0/1", valid_out, ctrl_out, count_out, ready_out); end
        idle(1'b1);
        idle(1'b1);
        checks++; if (seen(DW'(22)) || seen(DW'(21)) || valid_out !== 1'b0) begin
            failures++; $display("FAIL flush_discard got outs=%0d v=%b exp outs=0 v=0", dut_out.size(), valid_out); end
        // OUT in the flush cycle is still delivered, offered IN is dropped
        step(1'b1, DW'(40), 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, DW'(41), 2'b01, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        checks++; if (dut_out.size() != 1 || dut_out[0] !== DW'(40) || seen(DW'(41))) begin
            failures++; $display("FAIL flush_out_kept got n=%0d exp n=1 (40 only)", dut_out.size()); end
    endtask

    task automatic test_flush_reset_priority();
        dut_out.delete();
        step(1'b1, DW'(50), 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'(30), 2'b11, 1'b1, 1'b1, 1'b0);
        checks++; if (valid_out !== 1'b0 || count_out !== 2'd0 || ready_out !== 1'b1 || ctrl_out !== 2'b00) begin
            failures++; $display("FAIL rstflush_state got v=%b c=%0d r=%b ctrl=%b exp 0/0/1/00", valid_out, count_out, ready_out, ctrl_out); end
        checks++; if (data_out !== DW'(0)) begin failures++; $display("FAIL rstflush_data got=%0d exp=0", data_out); end
        idle(1'b1);
        idle(1'b1);
        checks++; if (seen(DW'(30)) || seen(DW'(50))) begin
            failures++; $display("FAIL rstflush_discard got n=%0d exp=0", dut_out.size()); end
        model_out.delete();
    endtask

    task automatic test_legacy_enable();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] prev_d;
        logic [CW-1:0] prev_c;
        logic          prev_v;
        int            nxt;
        bit            rdy;
        dut_out.delete();
        nxt = 60;
        for (int i = 0; i < 16; i++) begin
            rdy    = (i % 2 == 0);
            prev_d = data_out;
            prev_c = ctrl_out;
            prev_v = valid_out;
            if (mq_d.size() < 2) sent.push_back(DW'(nxt));
            step(1'b1, DW'(nxt), CW'(nxt), 1'b0, 1'b0, rdy);
            if (sent.size() > 0 && sent[$] === DW'(nxt)) nxt++;
            if (!rdy && prev_v) begin
                checks++; if (data_out !== prev_d || ctrl_out !== prev_c || valid_out !== 1'b1) begin
                    failures++; $display("FAIL legacy_stall cyc=%0d got d=%0d exp d=%0d", i, data_out, prev_d); end
            end
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        checks++; if (dut_out.size() != sent.size()) begin
            failures++; $display("FAIL legacy_count got=%0d exp=%0d", dut_out.size(), sent.size()); end
        else foreach (sent[i]) begin
            checks++; if (dut_out[i] !== sent[i]) begin
                failures++; $display("FAIL legacy_order idx=%0d got=%0d exp=%0d", i, dut_out[i], sent[i]); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] cur_d;
        logic [CW-1:0] cur_c;
        bit            have;
        bit            f;
        bit            r;
        bit            rdy;
        int            errs;
        dut_out.delete();
        model_out.delete();
        have = 1'b0;
        errs = 0;
        cur_d = '0;
        cur_c = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have && ($urandom_range(3) != 0)) begin
                cur_d = DW'({$urandom, $urandom, $urandom});
                cur_c = CW'($urandom);
                have  = 1'b1;
            end
            f   = ($urandom_range(15) == 0);
            r   = ($urandom_range(63) == 0);
            rdy = ($urandom_range(2) != 0);
            if (have && (r || f || mq_d.size() < 2)) begin
                step(1'b1, cur_d, cur_c, f, r, rdy);
                have = 1'b0;
            end else begin
                step(have, cur_d, cur_c, f, r, rdy);
            end
            checks++; if (valid_out !== (mq_d.size() != 0) || count_out !== 2'(mq_d.size())
                          || ready_out !== (mq_d.size() < 2)) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_status cyc=%0d got v=%b c=%0d r=%b exp c=%0d", i, valid_out, count_out, ready_out, mq_d.size());
            end
            checks++; if (ctrl_out !== ((mq_d.size() != 0) ? mq_c[0] : CW'(0))
                          || (mq_d.size() != 0 && data_out !== mq_d[0])) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_head cyc=%0d got d=%h ctrl=%b", i, data_out, ctrl_out);
            end
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        checks++; if (dut_out.size() != model_out.size()) begin
            failures++; $display("FAIL rand_out_count got=%0d exp=%0d", dut_out.size(), model_out.size()); end
        else foreach (model_out[i]) begin
            checks++; if (dut_out[i] !== model_out[i]) begin
                failures++; $display("FAIL rand_out idx=%0d got=%h exp=%h", i, dut_out[i], model_out[i]); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        ctrl_in  = '0;
        flush    = 1'b0;
        ready_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_reset_priority();
        test_legacy_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
